// File: rtl/hit_resolver_pkg.sv
// ----------------------------------------------------------------------------
// hit_resolver_pkg
// Shared definitions for the fighter character logic: the 4-bit character
// STATE encodings (used by both the char state handlers and hit_resolver),
// default stun lengths, winner encodings and a small active-attack helper.
// ----------------------------------------------------------------------------
package hit_resolver_pkg;

    typedef enum logic [3:0] {
        S_IDLE           = 4'd0,
        S_MOVE_FWD       = 4'd1,
        S_MOVE_BACK      = 4'd2,
        S_JUMP           = 4'd3,
        S_ATTACK         = 4'd4,
        S_ATTACK_END     = 4'd5,
        S_BLOCK          = 4'd6,
        S_DIR_ATTACK     = 4'd7,
        S_DIR_ATTACK_END = 4'd8,
        S_STUN           = 4'd9
    } char_state_e;

    localparam logic [4:0] HIT_STUN_DEF   = 5'd10;
    localparam logic [4:0] BLOCK_STUN_DEF = 5'd4;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // True for either attacking state; codes >= 4'b1010 fall through as idle.
    function automatic logic is_attack_state(input logic [3:0] st);
        return (st == S_ATTACK) || (st == S_DIR_ATTACK);
    endfunction

endpackage

// File: rtl/hit_resolver_attack_hit_detect.sv
// ----------------------------------------------------------------------------
// attack_hit_detect
// Decides whether one attacker's current attack may resolve this frame and
// keeps the consumed latch that limits each attack to a single resolution.
// Ports:
//   i_clk, i_rst     frame clock, synchronous active-high reset
//   i_enable         game-running qualifier
//   i_game_over      round finished; no more resolution
//   i_state          attacker STATE code
//   i_dist           |pos_p1 - pos_p2|, 11 bits
//   i_range          reach of a neutral attack
//   i_dir_range      reach of a directional attack
//   o_eligible       attack connects with the defender this frame
// ----------------------------------------------------------------------------
module attack_hit_detect
    import hit_resolver_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_game_over,
    input  logic [3:0]  i_state,
    input  logic [10:0] i_dist,
    input  logic [10:0] i_range,
    input  logic [10:0] i_dir_range,
    output logic        o_eligible
);

    logic r_consumed;
    logic w_in_range;

    assign w_in_range = ((i_state == S_ATTACK)     && (i_dist <= i_range)) ||
                        ((i_state == S_DIR_ATTACK) && (i_dist <= i_dir_range));

    assign o_eligible = w_in_range && !r_consumed && i_enable && !i_game_over;

    // Set once the attack resolves; re-armed only when the attacker leaves
    // both attacking states (or the game is paused).
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_consumed <= 1'b0;
        else if (!i_enable)
            r_consumed <= 1'b0;
        else if (o_eligible)
            r_consumed <= 1'b1;
        else if (!is_attack_state(i_state))
            r_consumed <= 1'b0;
    end

endmodule

// File: rtl/hit_resolver.sv
// ----------------------------------------------------------------------------
// hit_resolver
// Resolves attacks between P1 (left) and P2 (right), emits one-frame stun
// load pulses back to the char state handlers, tracks health and declares
// the round winner. All outputs registered, one CLOCK of latency.
// Ports:
//   CLOCK, RESET                    frame clock, synchronous active-high reset
//   enable                          game-running qualifier
//   state_p1/p2, block_p1/p2        handler STATE codes and block flags
//   pos_p1/p2                       X positions (unsigned pixels)
//   load_frame_p1/p2                one-cycle stun load to each handler
//   health_p1/p2                    remaining health
//   hit_p1/p2                       strobe: that player landed a (blocked) hit
//   game_over, winner               sticky round result
// ----------------------------------------------------------------------------
module hit_resolver
    import hit_resolver_pkg::*;
#(
    parameter int         ATTACK_RANGE     = 64,
    parameter int         DIR_ATTACK_RANGE = 96,
    parameter logic [4:0] HIT_STUN         = HIT_STUN_DEF,
    parameter logic [4:0] BLOCK_STUN       = BLOCK_STUN_DEF,
    parameter int         HEALTH_INIT      = 3
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       enable,
    input  logic [3:0] state_p1,
    input  logic [3:0] state_p2,
    input  logic       block_p1,
    input  logic       block_p2,
    input  logic [9:0] pos_p1,
    input  logic [9:0] pos_p2,
    output logic [4:0] load_frame_p1,
    output logic [4:0] load_frame_p2,
    output logic [1:0] health_p1,
    output logic [1:0] health_p2,
    output logic       hit_p1,
    output logic       hit_p2,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [1:0] HEALTH_RST = 2'(HEALTH_INIT);

    logic [10:0] w_dist;
    logic        w_elig_p1, w_elig_p2;
    logic [4:0]  w_load_p1, w_load_p2;
    logic        w_hit_p1, w_hit_p2;
    logic [1:0]  w_health_p1, w_health_p2;

    assign w_dist = (pos_p1 >= pos_p2) ? {1'b0, pos_p1 - pos_p2}
                                       : {1'b0, pos_p2 - pos_p1};

    attack_hit_detect u_atk_p1 (
        .i_clk       (CLOCK),
        .i_rst       (RESET),
        .i_enable    (enable),
        .i_game_over (game_over),
        .i_state     (state_p1),
        .i_dist      (w_dist),
        .i_range     (11'(ATTACK_RANGE)),
        .i_dir_range (11'(DIR_ATTACK_RANGE)),
        .o_eligible  (w_elig_p1)
    );

    attack_hit_detect u_atk_p2 (
        .i_clk       (CLOCK),
        .i_rst       (RESET),
        .i_enable    (enable),
        .i_game_over (game_over),
        .i_state     (state_p2),
        .i_dist      (w_dist),
        .i_range     (11'(ATTACK_RANGE)),
        .i_dir_range (11'(DIR_ATTACK_RANGE)),
        .o_eligible  (w_elig_p2)
    );

    // Both directions resolve independently so a same-frame trade lands
    // on both characters. A stunned defender absorbs the attack silently.
    always_comb begin
        w_load_p1   = 5'd0;
        w_load_p2   = 5'd0;
        w_hit_p1    = 1'b0;
        w_hit_p2    = 1'b0;
        w_health_p1 = health_p1;
        w_health_p2 = health_p2;

        if (w_elig_p1 && (state_p2 != S_STUN)) begin
            w_hit_p1 = 1'b1;
            if (block_p2) begin
                w_load_p2 = BLOCK_STUN;
            end else begin
                w_load_p2   = HIT_STUN;
                w_health_p2 = (health_p2 == 2'd0) ? 2'd0 : health_p2 - 2'd1;
            end
        end

        if (w_elig_p2 && (state_p1 != S_STUN)) begin
            w_hit_p2 = 1'b1;
            if (block_p1) begin
                w_load_p1 = BLOCK_STUN;
            end else begin
                w_load_p1   = HIT_STUN;
                w_health_p1 = (health_p1 == 2'd0) ? 2'd0 : health_p1 - 2'd1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            load_frame_p1 <= 5'd0;
            load_frame_p2 <= 5'd0;
            hit_p1        <= 1'b0;
            hit_p2        <= 1'b0;
            health_p1     <= HEALTH_RST;
            health_p2     <= HEALTH_RST;
            game_over     <= 1'b0;
            winner        <= WIN_NONE;
        end else if (enable && !game_over) begin
            load_frame_p1 <= w_load_p1;
            load_frame_p2 <= w_load_p2;
            hit_p1        <= w_hit_p1;
            hit_p2        <= w_hit_p2;
            health_p1     <= w_health_p1;
            health_p2     <= w_health_p2;
            if ((w_health_p1 == 2'd0) || (w_health_p2 == 2'd0)) begin
                game_over <= 1'b1;
                if (w_health_p1 == 2'd0 && w_health_p2 == 2'd0)
                    winner <= WIN_DRAW;
                else if (w_health_p2 == 2'd0)
                    winner <= WIN_P1;
                else
                    winner <= WIN_P2;
            end
        end else begin
            // Paused or round over: health and result hold, pulses drop.
            load_frame_p1 <= 5'd0;
            load_frame_p2 <= 5'd0;
            hit_p1        <= 1'b0;
            hit_p2        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hit_resolver.sv
module tb_hit_resolver;
    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] state_p1 = 4'd0, state_p2 = 4'd0;
    logic       block_p1 = 1'b0, block_p2 = 1'b0;
    logic [9:0] pos_p1 = 10'd100, pos_p2 = 10'd110;
    logic [4:0] load_frame_p1, load_frame_p2;
    logic [1:0] health_p1, health_p2;
    logic       hit_p1, hit_p2;
    logic       game_over;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    hit_resolver dut (
        .CLOCK(CLOCK), .RESET(RESET), .enable(enable),
        .state_p1(state_p1), .state_p2(state_p2),
        .block_p1(block_p1), .block_p2(block_p2),
        .pos_p1(pos_p1), .pos_p2(pos_p2),
        .load_frame_p1(load_frame_p1), .load_frame_p2(load_frame_p2),
        .health_p1(health_p1), .health_p2(health_p2),
        .hit_p1(hit_p1), .hit_p2(hit_p2),
        .game_over(game_over), .winner(winner)
    );

    always #5 CLOCK = ~CLOCK;

    // One frame: inputs set beforehand are sampled at the edge, outputs
    // are observed 1 time unit later.
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; enable = 1'b1;
        state_p1 = 4'd0; state_p2 = 4'd0; block_p1 = 1'b0; block_p2 = 1'b0;
        pos_p1 = 10'd100; pos_p2 = 10'd110;
        step();
        RESET = 1'b0;
    endtask

    // Setup only: attacker lands one neutral attack then returns to idle.
    task automatic land(input int who);
        if (who == 1) state_p1 = 4'b0100; else state_p2 = 4'b0100;
        step();
        state_p1 = 4'd0; state_p2 = 4'd0;
        step();
    endtask

    task automatic test_reset();
        RESET = 1'b1; enable = 1'b0;
        step();
        checks++;
        if (health_p1 !== 2'd3 || health_p2 !== 2'd3) begin
            errors++; $display("FAIL reset_health: got %0d/%0d exp 3/3", health_p1, health_p2);
        end
        checks++;
        if (load_frame_p1 !== 5'd0 || load_frame_p2 !== 5'd0 || hit_p1 !== 1'b0 ||
            hit_p2 !== 1'b0 || game_over !== 1'b0 || winner !== 2'b00) begin
            errors++; $display("FAIL reset_outputs: loads %0d/%0d hits %b%b go %b win %b exp all 0",
                               load_frame_p1, load_frame_p2, hit_p1, hit_p2, game_over, winner);
        end
    endtask

    task automatic test_range_boundary();
        do_reset();
        pos_p1 = 10'd100; pos_p2 = 10'd164; state_p1 = 4'b0100;
        step();
        checks++;
        if (load_frame_p2 !== 5'd10 || hit_p1 !== 1'b1 || health_p2 !== 2'd2) begin
            errors++; $display("FAIL range64_hit: load %0d hit %b hp2 %0d exp 10 1 2",
                               load_frame_p2, hit_p1, health_p2);
        end
        step();
        checks++;
        if (load_frame_p2 !== 5'd0 || hit_p1 !== 1'b0 || health_p2 !== 2'd2) begin
            errors++; $display("FAIL range64_second: load %0d hit %b hp2 %0d exp 0 0 2",
                               load_frame_p2, hit_p1, health_p2);
        end
        state_p1 = 4'b0101;
        step();
        pos_p2 = 10'd165; state_p1 = 4'b0100;
        step();
        checks++;
        if (load_frame_p2 !== 5'd0 || hit_p1 !== 1'b0 || health_p2 !== 2'd2) begin
            errors++; $display("FAIL range65_miss: load %0d hit %b hp2 %0d exp 0 0 2",
                               load_frame_p2, hit_p1, health_p2);
        end
        // P2 left of P1: distance is symmetric.
        state_p1 = 4'd0; step();
        pos_p1 = 10'd300; pos_p2 = 10'd236; state_p1 = 4'b0100;
        step();
        checks++;
        if (load_frame_p2 !== 5'd10 || health_p2 !== 2'd1) begin
            errors++; $display("FAIL range64_reversed: load %0d hp2 %0d exp 10 1", load_frame_p2, health_p2);
        end
        state_p1 = 4'd0;
    endtask

    task automatic test_block();
        do_reset();
        pos_p1 = 10'd100; pos_p2 = 10'd190; block_p2 = 1'b1; state_p1 = 4'b0111;
        step();
        checks++;
        if (load_frame_p2 !== 5'd4 || hit_p1 !== 1'b1 || health_p2 !== 2'd3) begin
            errors++; $display("FAIL block_dist90: load %0d hit %b hp2 %0d exp 4 1 3",
                               load_frame_p2, hit_p1, health_p2);
        end
        step();
        checks++;
        if (load_frame_p2 !== 5'd0) begin
            errors++; $display("FAIL block_pulse_width: load %0d exp 0", load_frame_p2);
        end
        state_p1 = 4'd0; step();
        pos_p2 = 10'd197; state_p1 = 4'b0111;
        step();
        checks++;
        if (load_frame_p2 !== 5'd0 || hit_p1 !== 1'b0) begin
            errors++; $display("FAIL dir_dist97_miss: load %0d hit %b exp 0 0", load_frame_p2, hit_p1);
        end
        // Directional attack unblocked at 96 takes health.
        state_p1 = 4'd0; step();
        pos_p2 = 10'd196; block_p2 = 1'b0; state_p1 = 4'b0111;
        step();
        checks++;
        if (load_frame_p2 !== 5'd10 || health_p2 !== 2'd2) begin
            errors++; $display("FAIL dir_dist96_hit: load %0d hp2 %0d exp 10 2", load_frame_p2, health_p2);
        end
        state_p1 = 4'd0;
    endtask

    task automatic test_single_resolution();
        int pulses;
        do_reset();
        pos_p2 = 10'd120; state_p1 = 4'b0100;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (load_frame_p2 != 5'd0) pulses++;
        end
        checks++;
        if (pulses !== 1 || health_p2 !== 2'd2) begin
            errors++; $display("FAIL single_resolution: pulses %0d hp2 %0d exp 1 2", pulses, health_p2);
        end
        state_p1 = 4'b0101; step();
        state_p1 = 4'b0100; step();
        checks++;
        if (load_frame_p2 !== 5'd10 || health_p2 !== 2'd1) begin
            errors++; $display("FAIL reattack: load %0d hp2 %0d exp 10 1", load_frame_p2, health_p2);
        end
        // Invalid state code is not an attack.
        state_p1 = 4'd0; step();
        state_p1 = 4'b1100; step();
        checks++;
        if (load_frame_p2 !== 5'd0 || health_p2 !== 2'd1) begin
            errors++; $display("FAIL invalid_state: load %0d hp2 %0d exp 0 1", load_frame_p2, health_p2);
        end
        state_p1 = 4'd0;
    endtask

    task automatic test_trade_draw();
        do_reset();
        land(1); land(1); land(2); land(2);
        checks++;
        if (health_p1 !== 2'd1 || health_p2 !== 2'd1 || game_over !== 1'b0) begin
            errors++; $display("FAIL trade_setup: hp %0d/%0d go %b exp 1/1 0", health_p1, health_p2, game_over);
        end
        state_p1 = 4'b0100; state_p2 = 4'b0100;
        step();
        checks++;
        if (load_frame_p1 !== 5'd10 || load_frame_p2 !== 5'd10 || hit_p1 !== 1'b1 || hit_p2 !== 1'b1) begin
            errors++; $display("FAIL trade_loads: loads %0d/%0d hits %b%b exp 10/10 11",
                               load_frame_p1, load_frame_p2, hit_p1, hit_p2);
        end
        checks++;
        if (health_p1 !== 2'd0 || health_p2 !== 2'd0 || game_over !== 1'b1 || winner !== 2'b11) begin
            errors++; $display("FAIL draw_result: hp %0d/%0d go %b win %b exp 0/0 1 11",
                               health_p1, health_p2, game_over, winner);
        end
        state_p1 = 4'd0; state_p2 = 4'd0; step();
        state_p1 = 4'b0100; step();
        checks++;
        if (load_frame_p2 !== 5'd0 || hit_p1 !== 1'b0 || game_over !== 1'b1 || winner !== 2'b11) begin
            errors++; $display("FAIL after_game_over: load %0d hit %b go %b win %b exp 0 0 1 11",
                               load_frame_p2, hit_p1, game_over, winner);
        end
        state_p1 = 4'd0;
    endtask

    task automatic test_p1_wins();
        do_reset();
        land(1); land(1); land(1);
        checks++;
        if (health_p2 !== 2'd0 || game_over !== 1'b1 || winner !== 2'b01) begin
            errors++; $display("FAIL p1_wins: hp2 %0d go %b win %b exp 0 1 01", health_p2, game_over, winner);
        end
    endtask

    task automatic test_stunned_defender();
        do_reset();
        state_p2 = 4'b1001; state_p1 = 4'b0100;
        step();
        checks++;
        if (load_frame_p2 !== 5'd0 || hit_p1 !== 1'b0 || health_p2 !== 2'd3) begin
            errors++; $display("FAIL stunned_defender: load %0d hit %b hp2 %0d exp 0 0 3",
                               load_frame_p2, hit_p1, health_p2);
        end
        state_p2 = 4'd0;
        step();
        checks++;
        if (load_frame_p2 !== 5'd0 || hit_p1 !== 1'b0 || health_p2 !== 2'd3) begin
            errors++; $display("FAIL stun_consumed: load %0d hit %b hp2 %0d exp 0 0 3",
                               load_frame_p2, hit_p1, health_p2);
        end
        state_p1 = 4'd0;
    endtask

    task automatic test_reset_mid_round();
        do_reset();
        land(2); land(2); land(1);
        checks++;
        if (health_p1 !== 2'd1 || health_p2 !== 2'd2) begin
            errors++; $display("FAIL mid_setup: hp %0d/%0d exp 1/2", health_p1, health_p2);
        end
        state_p1 = 4'b0100; RESET = 1'b1;
        step();
        checks++;
        if (health_p1 !== 2'd3 || health_p2 !== 2'd3 || load_frame_p2 !== 5'd0 ||
            hit_p1 !== 1'b0 || game_over !== 1'b0) begin
            errors++; $display("FAIL reset_priority: hp %0d/%0d load %0d hit %b go %b exp 3/3 0 0 0",
                               health_p1, health_p2, load_frame_p2, hit_p1, game_over);
        end
        RESET = 1'b0; state_p1 = 4'd0;
    endtask

    task automatic test_enable();
        do_reset();
        enable = 1'b0; state_p1 = 4'b0100;
        step();
        checks++;
        if (load_frame_p2 !== 5'd0 || hit_p1 !== 1'b0 || health_p2 !== 2'd3) begin
            errors++; $display("FAIL disabled_no_load: load %0d hit %b hp2 %0d exp 0 0 3",
                               load_frame_p2, hit_p1, health_p2);
        end
        enable = 1'b1;
        step();
        checks++;
        if (load_frame_p2 !== 5'd10 || health_p2 !== 2'd2) begin
            errors++; $display("FAIL enable_first_hit: load %0d hp2 %0d exp 10 2", load_frame_p2, health_p2);
        end
        // Pause while still attacking clears the latch: same attack hits again.
        enable = 1'b0; step();
        enable = 1'b1; step();
        checks++;
        if (load_frame_p2 !== 5'd10 || health_p2 !== 2'd1) begin
            errors++; $display("FAIL enable_latch_cleared: load %0d hp2 %0d exp 10 1", load_frame_p2, health_p2);
        end
        state_p1 = 4'd0;
    endtask

    initial begin
        test_reset();
        test_range_boundary();
        test_block();
        test_single_resolution();
        test_trade_draw();
        test_p1_wins();
        test_stunned_defender();
        test_reset_mid_round();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hit_resolver.md
Name: hit_resolver

Overview:
- Sits directly downstream of the two per-character state handlers (char_no 0 = P1 on the left, char_no 1 = P2 on the right).
- Each enabled frame it reads both characters' STATE codes, block flags and X positions, and decides whether an active attack connects.
- It produces the one-frame load_frame stun pulses that feed back into each handler.
- It also tracks health and declares the winner.

Parameters:
- ATTACK_RANGE, 64: max |pos_p1 - pos_p2| for a neutral attack (state 4'b0100) to connect.
- DIR_ATTACK_RANGE, 96: max distance for a directional attack (state 4'b0111) to connect.
- HIT_STUN, 5'd10: stun frames loaded into an unblocked defender.
- BLOCK_STUN, 5'd4: stun frames loaded into a blocking defender.
- HEALTH_INIT, 3: starting health per character; HEALTH_INIT must be at most 3.

Ports:
- CLOCK  in  1  frame clock, shared with the char state handlers.
- RESET  in  1  synchronous, active-high reset.
- enable  in  1  game-running qualifier, same signal as the handlers' enable.
- state_p1  in  4  P1 handler STATE.
- state_p2  in  4  P2 handler STATE.
- block_p1  in  1  P1 handler block_flag.
- block_p2  in  1  P2 handler block_flag.
- pos_p1  in  10  P1 X position, unsigned pixels.
- pos_p2  in  10  P2 X position, unsigned pixels.
- load_frame_p1  out  5  stun pulse to the P1 handler.
- load_frame_p2  out  5  stun pulse to the P2 handler.
- health_p1  out  2  P1 remaining health.
- health_p2  out  2  P2 remaining health.
- hit_p1  out  1  one-cycle strobe: P1 landed a hit or a blocked hit.
- hit_p2  out  1  one-cycle strobe: P2 landed a hit or a blocked hit.
- game_over  out  1  sticky end-of-round flag.
- winner  out  2  round result: 00 none, 01 P1, 10 P2, 11 draw.

Behaviour:
- Reset (synchronous, on CLOCK):
  - load_frame_p1 and load_frame_p2 = 0.
  - hit_p1 and hit_p2 = 0.
  - health_p1 and health_p2 = HEALTH_INIT.
  - game_over = 0, winner = 00.
  - Both consumed latches = 0.
  - RESET has priority over every other input, including mid-stun and after game over.
- All outputs are registered. Inputs sampled at edge N affect outputs after edge N; latency is one CLOCK.
- Distance: dist = |pos_p1 - pos_p2|, computed unsigned in 11 bits; no wrap.
- Attacker X is eligible when all of the following hold:
  - state_X is 4'b0100 and dist <= ATTACK_RANGE, or state_X is 4'b0111 and dist <= DIR_ATTACK_RANGE;
  - consumed_X = 0;
  - enable = 1;
  - game_over = 0.
- Consumed latch:
  - consumed_X is set on any cycle where attacker X is eligible.
  - It clears when state_X is in neither active state (4'b0100, 4'b0111).
  - Each attack therefore resolves at most once.
- Resolution against defender Y when attacker X is eligible:
  - state_Y == 4'b1001 (stun): attack is consumed; no load, no health change, no hit strobe.
  - block_Y = 1: load_frame_Y = BLOCK_STUN, hit_X = 1, health unchanged.
  - Otherwise: load_frame_Y = HIT_STUN, hit_X = 1, health_Y decrements, saturating at 0.
- Pulse shape:
  - load_frame_* is nonzero for exactly one cycle, then returns to 0.
  - The consumed latch guarantees at least one zero cycle between pulses, which the handler's rising-edge detect (prev == 0) requires.
- Simultaneous attacks (both eligible in the same cycle): resolve both independently as a trade. Both loads fire and both health values may decrement.
- Game over:
  - When either health reaches 0 after an update, game_over = 1 on the same registered cycle.
  - winner = 01 if only health_p2 is 0, 10 if only health_p1 is 0, 11 if both are 0.
  - game_over and winner are sticky until RESET.
  - During game over: no further resolution, loads = 0, strobes = 0.
- enable = 0: loads and strobes forced to 0, consumed latches cleared, health and game_over held.
- Invalid state codes (>= 4'b1010) are treated as non-active.

Decomposition:
- Shared package holds:
  - the 4-bit state encodings (S_IDLE = 0 through S_STUN = 9);
  - default HIT_STUN and BLOCK_STUN values;
  - the winner encodings.
  - The char state handler migrates to the same package.
- One natural sub-module, attack_hit_detect, instantiated twice (P1 attacker and P2 attacker).
  - Inputs: attacker state, distance, ranges.
  - Contains the consumed latch.
  - Output: eligible.
  - Defender handling and health logic stay in the top.

Test Plan:
- Range boundary: P1 state 0100 for 2 cycles, pos 100/164 (dist 64) -> load_frame_p2 = 10 for one cycle, then 0; health_p2 3 -> 2; hit_p1 one pulse. Repeat at dist 65 -> no load, health unchanged.
- Block: P1 state 0111, dist 90, block_p2 = 1 -> load_frame_p2 = 4 for one cycle; health_p2 stays 3. Same at dist 97 -> nothing.
- Single resolution: P1 held in 0100 for 3 cycles in range -> exactly one pulse. P1 returns to 0101, then re-enters 0100 -> second pulse.
- Trade and draw: health both 1, both in 0100 at dist 10 in the same cycle -> both loads 10, both health 0, game_over = 1, winner = 11. Further attacks -> no outputs until RESET.
- Stunned defender: state_p2 = 1001 while P1 is active in range -> no load, health unchanged. P1 staying active after P2 leaves stun -> still no hit.
- RESET mid-round: health 1/2 with a load pulse pending -> next cycle health 3/3, loads 0, game_over 0. enable = 0 while P1 is active -> no load and consumed latch cleared.
